rv_mul_iter_param: RTL and testbench

- Parametrised iterative multiplier for the RV32M/RV64M execute stage. Successor to the fixed-width multiplier top.
- Supports MUL, MULH, MULHSU and MULHU, selected by a single op code. Consumes DIGIT_W multiplier bits per cycle.
- Uses a valid/ready handshake on both the request and result sides, and supports kill of an in-flight operation.
- Sits beside the ALU. It is started by the decode/issue stage and drained by writeback.

---
 rtl/rv_mul_iter_param_if.sv | 25 ++
 rtl/rv_mul_iter_param.sv | 193 +++++++++++++++++++
 tb/tb_rv_mul_iter_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_mul_iter_param_if.sv
// rtl/rv_mul_iter_param_if.sv - request/result handshake bundle for rv_mul_iter_param
interface rv_mul_iter_param_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      op_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            kill_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output req_valid_i, op_i, op_a_i, op_b_i, kill_i, res_ready_i,
        input  req_ready_o, res_valid_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, op_i, op_a_i, op_b_i, kill_i, res_ready_i,
        output req_ready_o, res_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/rv_mul_iter_param.sv
// rtl/rv_mul_iter_param.sv - iterative RV32M/RV64M MUL/MULH/MULHSU/MULHU unit, DIGIT_W multiplier bits per cycle
// Optional product-reuse fusion enabled by defining RV_MUL_FUSE_EN.
module rv_mul_iter_param #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv_mul_iter_param_if.slave bus
);
    localparam int N_ITER = XLEN / DIGIT_W;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int PW     = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     a_sh;
    logic [XLEN-1:0]   b_sh;
    logic [1:0]        op_q;
    logic              b_signed_q;

    logic              req_ready_r;
    logic              res_valid_r;
    logic              busy_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_in;
    logic              b_signed_in;
    logic [PW-1:0]     a_ext_in;
    logic [PW-1:0]     digit_ext;
    logic              last_iter;
    logic              neg_digit;
    logic [PW-1:0]     acc_next;
    logic [XLEN-1:0]   result_sel;
    logic              fuse_hit;

`ifdef RV_MUL_FUSE_EN
    logic              fuse_valid;
    logic [XLEN-1:0]   tag_a;
    logic [XLEN-1:0]   tag_b;
    logic              tag_as;
    logic              tag_bs;
    logic [PW-1:0]     fuse_prod;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              a_signed_q;

    // Signedness is part of the tag: MULH and MULHU of the same operands give different products.
    assign fuse_hit = fuse_valid && (bus.op_a_i == tag_a) && (bus.op_b_i == tag_b)
                      && (a_signed_in == tag_as) && (b_signed_in == tag_bs);
`else
    assign fuse_hit = 1'b0;
`endif

    assign a_signed_in = (bus.op_i != 2'b11);
    assign b_signed_in = ~bus.op_i[1];

    always_comb begin
        a_ext_in = {{XLEN{a_signed_in & bus.op_a_i[XLEN-1]}}, bus.op_a_i};
        digit_ext = {{(PW-DIGIT_W){1'b0}}, b_sh[DIGIT_W-1:0]};
        last_iter = (cnt == CNT_W'(N_ITER - 1));
        // A signed multiplier's top digit carries negative weight: subtract 2^DIGIT_W * A once.
        neg_digit = last_iter && b_signed_q && b_sh[DIGIT_W-1];
        acc_next = acc + (a_sh * digit_ext) - (neg_digit ? (a_sh << DIGIT_W) : '0);
        result_sel = (op_q == 2'b00) ? acc[XLEN-1:0] : acc[PW-1:XLEN];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            op_q        <= 2'b00;
            b_signed_q  <= 1'b0;
            req_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= '0;
`ifdef RV_MUL_FUSE_EN
            fuse_valid  <= 1'b0;
            tag_a       <= '0;
            tag_b       <= '0;
            tag_as      <= 1'b0;
            tag_bs      <= 1'b0;
            fuse_prod   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_signed_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.kill_i) begin
`ifdef RV_MUL_FUSE_EN
                        fuse_valid <= 1'b0;
`endif
                    end else if (bus.req_valid_i) begin
                        op_q        <= bus.op_i;
                        b_signed_q  <= b_signed_in;
                        a_sh        <= a_ext_in;
                        b_sh        <= bus.op_b_i;
                        cnt         <= '0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef RV_MUL_FUSE_EN
                        a_q         <= bus.op_a_i;
                        b_q         <= bus.op_b_i;
                        a_signed_q  <= a_signed_in;
`endif
                        if (fuse_hit) begin
`ifdef RV_MUL_FUSE_EN
                            acc <= fuse_prod;
`endif
                            state <= DONE;
                        end else begin
                            acc   <= '0;
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (bus.kill_i) begin
                        state       <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef RV_MUL_FUSE_EN
                        fuse_valid  <= 1'b0;
`endif
                    end else begin
                        acc  <= acc_next;
                        a_sh <= a_sh << DIGIT_W;
                        b_sh <= b_sh >> DIGIT_W;
                        cnt  <= cnt + 1'b1;
                        if (last_iter) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.kill_i) begin
                        state       <= IDLE;
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef RV_MUL_FUSE_EN
                        fuse_valid  <= 1'b0;
`endif
                    end else if (!res_valid_r) begin
                        // First DONE cycle registers the selected half; it then holds until taken.
                        result_r    <= result_sel;
                        res_valid_r <= 1'b1;
                    end else if (bus.res_ready_i) begin
                        state       <= IDLE;
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef RV_MUL_FUSE_EN
                        fuse_valid  <= 1'b1;
                        tag_a       <= a_q;
                        tag_b       <= b_q;
                        tag_as      <= a_signed_q;
                        tag_bs      <= b_signed_q;
                        fuse_prod   <= acc;
`endif
                    end
                end

                default: begin
                    state       <= IDLE;
                    res_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_r;
    assign bus.res_valid_o = res_valid_r;
    assign bus.busy_o      = busy_r;
    assign bus.result_o    = result_r;
endmodule

// File: tb/tb_rv_mul_iter_param.sv
// tb/tb_rv_mul_iter_param.sv - directed self-checking bench for rv_mul_iter_param (32/8 and 64/1 instances)
module tb_rv_mul_iter_param;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rv_mul_iter_param_if #(.XLEN(32)) bus32();
    rv_mul_iter_param_if #(.XLEN(64)) bus64();

    rv_mul_iter_param #(.XLEN(32), .DIGIT_W(8)) dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus32.slave)
    );

    rv_mul_iter_param #(.XLEN(64), .DIGIT_W(1)) dut64 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns once res_valid_o is seen or the bound expires.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        bus32.req_valid_i = 1'b1;
        bus32.op_i        = op;
        bus32.op_a_i      = a;
        bus32.op_b_i      = b;
        @(posedge clk); #1;
        bus32.req_valid_i = 1'b0;
        lat = 0;
        while (bus32.res_valid_o !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus32.result_o;
    endtask

    task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        bus64.req_valid_i = 1'b1;
        bus64.op_i        = op;
        bus64.op_a_i      = a;
        bus64.op_b_i      = b;
        @(posedge clk); #1;
        bus64.req_valid_i = 1'b0;
        lat = 0;
        while (bus64.res_valid_o !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus64.result_o;
    endtask

    initial begin
        logic [31:0] r32;
        logic [63:0] r64;
        logic [31:0] held;
        int          lat;
        int          fused_lat;
        logic        stable;
        logic        seen;

        total = 0;
        bad   = 0;
`ifdef RV_MUL_FUSE_EN
        fused_lat = 1;
`else
        fused_lat = 5;
`endif
        rst = 1'b1;
        bus32.req_valid_i = 1'b0; bus32.op_i = 2'b00; bus32.op_a_i = '0; bus32.op_b_i = '0;
        bus32.kill_i = 1'b0; bus32.res_ready_i = 1'b1;
        bus64.req_valid_i = 1'b0; bus64.op_i = 2'b00; bus64.op_a_i = '0; bus64.op_b_i = '0;
        bus64.kill_i = 1'b0; bus64.res_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus32.req_ready_o), 64'd1);
        check("rst_res_valid", 64'(bus32.res_valid_o), 64'd0);
        check("rst_busy",      64'(bus32.busy_o),      64'd0);
        check("rst_result",    64'(bus32.result_o),    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL 7 x 6
        run32(2'b00, 32'd7, 32'd6, r32, lat);
        check("mul_7x6", 64'(r32), 64'h2A);
        check("mul_7x6_lat", 64'(lat), 64'd5);
        @(posedge clk); #1;
        check("mul_7x6_idle", 64'(bus32.req_ready_o), 64'd1);

        // All-ones under the three upper-half ops
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r32, lat);
        check("mulh_ones", 64'(r32), 64'h0000_0000);
        @(posedge clk); #1;
        run32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r32, lat);
        check("mulhu_ones", 64'(r32), 64'hFFFF_FFFE);
        @(posedge clk); #1;
        run32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r32, lat);
        check("mulhsu_ones", 64'(r32), 64'hFFFF_FFFF);
        check("mulhsu_ones_lat", 64'(lat), 64'd5);
        @(posedge clk); #1;

        // Most-negative squared, then the MUL of the same pair
        run32(2'b01, 32'h8000_0000, 32'h8000_0000, r32, lat);
        check("mulh_min", 64'(r32), 64'h4000_0000);
        @(posedge clk); #1;
        run32(2'b00, 32'h8000_0000, 32'h8000_0000, r32, lat);
        check("mul_min", 64'(r32), 64'h0);
        check("mul_min_lat", 64'(lat), 64'(fused_lat));
        @(posedge clk); #1;

        // Zero operands still run the full iteration count
        run32(2'b00, 32'd0, 32'd0, r32, lat);
        check("mul_zero", 64'(r32), 64'h0);
        check("mul_zero_lat", 64'(lat), 64'd5);
        @(posedge clk); #1;

        // Backpressure in DONE
        bus32.res_ready_i = 1'b0;
        run32(2'b00, 32'h0000_1234, 32'h0000_0010, r32, lat);
        check("bp_result", 64'(r32), 64'h0001_2340);
        held   = bus32.result_o;
        stable = 1'b1;
        bus32.req_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus32.res_valid_o !== 1'b1 || bus32.result_o !== held || bus32.req_ready_o !== 1'b0)
                stable = 1'b0;
        end
        bus32.req_valid_i = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        bus32.res_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(bus32.res_valid_o), 64'd0);
        check("bp_release_ready", 64'(bus32.req_ready_o), 64'd1);

        // Kill on the second CALC cycle of MUL 3 x 5
        bus32.req_valid_i = 1'b1; bus32.op_i = 2'b00; bus32.op_a_i = 32'd3; bus32.op_b_i = 32'd5;
        @(posedge clk); #1;
        bus32.req_valid_i = 1'b0;
        @(posedge clk); #1;
        bus32.kill_i = 1'b1;
        @(posedge clk); #1;
        bus32.kill_i = 1'b0;
        check("kill_idle_ready", 64'(bus32.req_ready_o), 64'd1);
        check("kill_idle_busy",  64'(bus32.busy_o),      64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus32.res_valid_o !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("kill_no_valid", 64'(seen), 64'd0);
        run32(2'b00, 32'd2, 32'd2, r32, lat);
        check("after_kill_2x2", 64'(r32), 64'h4);
        @(posedge clk); #1;

        // Asynchronous reset between edges in CALC
        bus32.req_valid_i = 1'b1; bus32.op_i = 2'b00; bus32.op_a_i = 32'd9; bus32.op_b_i = 32'd9;
        @(posedge clk); #1;
        bus32.req_valid_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_req_ready", 64'(bus32.req_ready_o), 64'd1);
        check("arst_res_valid", 64'(bus32.res_valid_o), 64'd0);
        check("arst_busy",      64'(bus32.busy_o),      64'd0);
        check("arst_result",    64'(bus32.result_o),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run32(2'b00, 32'd7, 32'd6, r32, lat);
        check("rerun_7x6", 64'(r32), 64'h2A);
        check("rerun_7x6_lat", 64'(lat), 64'd5);
        @(posedge clk); #1;

        // 64-bit, one bit per cycle
        run64(2'b00, 64'd7, 64'd6, r64, lat);
        check("x64_mul_7x6", r64, 64'h2A);
        check("x64_mul_7x6_lat", 64'(lat), 64'd65);
        @(posedge clk); #1;
        run64(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r64, lat);
        check("x64_mulh_min", r64, 64'h4000_0000_0000_0000);
        @(posedge clk); #1;
        run64(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, r64, lat);
        check("x64_mulhsu_neg", r64, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
